// File: rtl/hex2ascii_pkg.sv
// hex2ascii_pkg: shared constants and FSM state type for the hex-to-ASCII serializer
package hex2ascii_pkg;
  localparam int CASE_UPPER = 0;
  localparam int CASE_LOWER = 1;
  localparam int CASE_MIXED = 2;
  localparam logic [6:0] ASCII_0 = 7'h30;
  localparam logic [6:0] ASCII_X = 7'h78;
  typedef enum logic [2:0] {IDLE, PRE0, PRE1, DIG, TERM} state_e;
endpackage

// File: rtl/hex2ascii_serializer_if.sv
// hex2ascii_serializer_if: word-in / character-out handshake bundle
//   in_valid/in_ready/in_data          : word producer side
//   out_valid/out_ready/out_char/out_last : character sink side
//   master = producer/sink environment, slave = serializer
interface hex2ascii_serializer_if #(parameter int WIDTH = 32);
  logic in_valid;
  logic in_ready;
  logic [WIDTH-1:0] in_data;
  logic out_valid;
  logic out_ready;
  logic [6:0] out_char;
  logic out_last;
  modport master(output in_valid, in_data, out_ready, input in_ready, out_valid, out_char, out_last);
  modport slave(input in_valid, in_data, out_ready, output in_ready, out_valid, out_char, out_last);
endinterface

// File: rtl/hex2ascii_nibble.sv
// hex2ascii_nibble: 4-bit value to 7-bit ASCII hex digit
//   nib_i  : nibble to convert
//   char_o : ASCII digit, letter case chosen by CASE_MODE
module hex2ascii_nibble
  import hex2ascii_pkg::*;
#(
  parameter int CASE_MODE = CASE_MIXED
) (
  input  logic [3:0] nib_i,
  output logic [6:0] char_o
);
  logic lower;
  always_comb begin
    // mixed case lowers only b and d so they stay distinct from 8 and 0 on seven-segment displays
    lower = CASE_MODE == CASE_LOWER || (CASE_MODE == CASE_MIXED && (nib_i == 4'hB || nib_i == 4'hD));
    char_o = nib_i < 4'hA ? ASCII_0 + 7'(nib_i) : lower ? 7'h57 + 7'(nib_i) : 7'h37 + 7'(nib_i);
  end
endmodule

// File: rtl/hex2ascii_serializer.sv
// hex2ascii_serializer: binary word to stream of ASCII hex characters, one per beat
//   clk, reset_n : clock, asynchronous active-low reset
//   bus          : word input handshake and registered character output handshake
//   busy         : high from word acceptance until the last character is handshaken
module hex2ascii_serializer
  import hex2ascii_pkg::*;
#(
  parameter int         WIDTH          = 32,
  parameter int         CASE_MODE      = CASE_MIXED,
  parameter int         PREFIX_EN      = 0,
  parameter int         SUPPRESS_ZEROS = 0,
  parameter int         TERM_EN        = 0,
  parameter logic [6:0] TERM_CHAR      = 7'h0A
) (
  input  logic                 clk,
  input  logic                 reset_n,
  hex2ascii_serializer_if.slave bus,
  output logic                 busy
);
  localparam int D = WIDTH / 4;
  localparam int IW = D > 1 ? $clog2(D) : 1;
  if (WIDTH == 0 || WIDTH % 4 != 0) begin : g_bad_width
    $error("hex2ascii_serializer: WIDTH must be a nonzero multiple of 4");
  end
  state_e state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic [IW-1:0] idx_q, idx_d, first_idx;
  logic [6:0] char_q, char_d, dig_char;
  logic valid_q, valid_d, last_q, last_d, adv;
  logic [3:0] nib;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      data_q  <= '0;
      idx_q   <= '0;
      char_q  <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      char_q  <= char_d;
      valid_q <= valid_d;
      last_q  <= last_d;
    end
  end
  // highest nonzero nibble wins, so suppressed zeros cost no cycles; all-zero word gives digit 0
  always_comb begin
    first_idx = '0;
    for (int i = 0; i < D; i++) first_idx = bus.in_data[4*i +: 4] != 4'h0 ? IW'(i) : first_idx;
    first_idx = SUPPRESS_ZEROS != 0 ? first_idx : IW'(D - 1);
  end
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    idx_d   = idx_q;
    adv     = valid_q & bus.out_ready;
    case (state_q)
      IDLE: if (bus.in_valid) begin
        data_d  = bus.in_data;
        idx_d   = first_idx;
        state_d = PREFIX_EN != 0 ? PRE0 : DIG;
      end
      PRE0: state_d = adv ? PRE1 : state_q;
      PRE1: state_d = adv ? DIG : state_q;
      DIG: if (adv) begin
        state_d = idx_q != '0 ? DIG : TERM_EN != 0 ? TERM : IDLE;
        idx_d   = idx_q != '0 ? idx_q - 1'b1 : idx_q;
      end
      TERM: state_d = adv ? IDLE : state_q;
      default: state_d = IDLE;
    endcase
  end
  assign nib = 4'(data_d >> {idx_d, 2'b00});
  hex2ascii_nibble #(.CASE_MODE(CASE_MODE)) u_nib (.nib_i(nib), .char_o(dig_char));
  // output registers are loaded from the next state, giving one-cycle latency and stall-stable data
  always_comb begin
    valid_d = state_d != IDLE;
    char_d = state_d == PRE0 ? ASCII_0 : state_d == PRE1 ? ASCII_X : state_d == DIG ? dig_char : state_d == TERM ? TERM_CHAR : 7'h00;
    last_d = state_d == TERM || (state_d == DIG && idx_d == '0 && TERM_EN == 0);
    bus.in_ready  = state_q == IDLE;
    bus.out_valid = valid_q;
    bus.out_char  = char_q;
    bus.out_last  = last_q;
    busy = state_q != IDLE;
  end
endmodule

// File: doc/hex2ascii_serializer.md
Name: hex2ascii_serializer

Overview:
Converts a parametrised-width binary word into a stream of 7-bit ASCII hex characters, one character per output beat.
- Optional "0x" prefix, leading-zero suppression and terminator character.
- Selectable letter-case mode, including the mixed-case style used for seven-segment-friendly display ("A b C d E F").
- Sits between a word producer (debug/trace logic) and a character sink (UART TX or text-display writer), with valid/ready handshakes on both sides.

Parameters:
WIDTH, 32, input word width in bits; must be a nonzero multiple of 4 (elaboration error otherwise); D = WIDTH/4 digits
CASE_MODE, 2, 0 = upper "ABCDEF", 1 = lower "abcdef", 2 = mixed "AbCdEF"
PREFIX_EN, 0, 1 = emit "0x" (0x30, 0x78) before the digits
SUPPRESS_ZEROS, 0, 1 = omit leading zero digits; at least the least-significant digit is always emitted
TERM_EN, 0, 1 = emit TERM_CHAR after the last digit
TERM_CHAR, 7'h0A, terminator character

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
in_valid  in  1  producer presents in_data
in_ready  out  1  block can accept a word
in_data  in  WIDTH  word to convert, captured on in_valid & in_ready
out_valid  out  1  out_char is valid
out_ready  in  1  sink accepts out_char
out_char  out  7  ASCII character
out_last  out  1  marks the final character of the current word
busy  out  1  high from word acceptance until the last character is handshaken

Behaviour:
- Reset (async assert, release sampled on clk): state IDLE; out_valid = 0, out_char = 0, out_last = 0, busy = 0, captured word cleared. in_ready = (state == IDLE), so it reads 1 during reset, but no word is accepted while reset_n is low.
- FSM states:
  - IDLE: in_ready = 1. On accept, capture the word and compute the first digit index; go to PRE0 if PREFIX_EN, else DIG.
  - PRE0: out_char = '0'. On handshake go to PRE1.
  - PRE1: out_char = 'x'. On handshake go to DIG.
  - DIG: walks the digit index from the first emitted digit down to 0. After digit 0 is handshaken, go to TERM if TERM_EN, else IDLE.
  - TERM: out_char = TERM_CHAR. On handshake go to IDLE.
- Output register:
  - out_char, out_valid and out_last are registered.
  - The first character is valid the cycle after acceptance (latency 1).
  - Advance only on out_valid & out_ready. With out_ready held high, throughput is one character per cycle with no bubbles within a word.
  - With out_valid high and out_ready low, out_char and out_last hold stable and out_valid stays high.
- out_last is high exactly on the final character: TERM_CHAR if TERM_EN, else digit 0.
- Between words: one idle cycle after the last handshake (in_ready rises in the cycle after). Back-to-back words are separated by exactly one bubble.
- Leading-zero suppression:
  - The first nonzero nibble index (MSB first) is computed at capture with a priority encoder, so there are no skip cycles.
  - An all-zero word emits a single '0'.
  - The prefix and terminator are unaffected by suppression.
- Character count per word = 2·PREFIX_EN + (number of emitted digits) + TERM_EN; maximum D + 3.
- Nibble mapping:
  - 0-9 map to 0x30-0x39.
  - A-F by mode:
    - upper: 0x41-0x46
    - lower: 0x61-0x66
    - mixed: A 0x41, b 0x62, C 0x43, d 0x64, E 0x45, F 0x46
- Digit index counter width is $clog2(D), minimum 1. Digit 0 is the final digit, so there is no wrap-around.
- in_data is ignored outside IDLE, and changes to in_data after capture have no effect.
- Reset mid-word: the output stream is aborted immediately (out_valid drops asynchronously), the captured word is discarded, and nothing is emitted after reset release.

Decomposition:
- Package hex2ascii_pkg:
  - CASE_UPPER / CASE_LOWER / CASE_MIXED constants
  - ASCII constants for '0' and 'x'
  - FSM state enum (IDLE, PRE0, PRE1, DIG, TERM)
- One sub-module, hex2ascii_nibble: combinational 4-bit to 7-bit map, parametrised by CASE_MODE.
- FSM, counter and priority encoder stay in the top level.

Test Plan:
1. WIDTH=16, CASE_MODE=2, PREFIX_EN=1, TERM_EN=1; in_data=16'hBEEF, out_ready=1 -> 0x30, 0x78, 0x62, 0x45, 0x45, 0x46, 0x0A on 7 consecutive cycles starting 1 cycle after accept; out_last only on 0x0A; in_ready high again 1 cycle after.
2. SUPPRESS_ZEROS=1, WIDTH=16, no prefix/term; 16'h000A -> single 0x41 with out_last=1. Then 16'h0000 -> single 0x30 with out_last=1.
3. CASE_MODE=1, WIDTH=16; 16'hCAFE with out_ready low for 3 cycles while the second char is presented -> 0x61 held stable with out_valid=1 during the stall; full sequence 0x63, 0x61, 0x66, 0x65, nothing dropped or duplicated.
4. Back-to-back: in_valid held high with 16'h1234 then 16'h5678, out_ready=1 -> "1234" then one bubble then "5678"; in_data changes during "1234" are ignored.
5. Reset mid-word: WIDTH=32, 32'hDEADBEEF, assert reset_n=0 after the third character -> out_valid=0 immediately, busy=0, in_ready=1; after release nothing is emitted until a new word is accepted.
